// File: rtl/pkt_read_sequencer_if.sv
// Bundle of the sequencer's scheduler, SRAM read-side and framed output signals.
// master: seen from pkt_read_sequencer.
// slave : seen from the environment (scheduler, SRAM, downstream).
//   req_*          descriptor handshake from the port scheduler
//   out_hold       downstream pause, honoured at page boundaries
//   rd_*           page-down strobe, page address, jump-table and slice data
//   out_*          framed 16-bit slice stream with sop/eop
//   err_runaway    pulse when the page-count guard aborts a packet
//   busy           sequencer is not idle
interface pkt_read_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_head;
  logic [11:0] req_tail;
  logic [2:0]  req_last_batch;
  logic        out_hold;
  logic        rd_page_down;
  logic [3:0]  rd_sram;
  logic [7:0]  rd_page;
  logic [11:0] rd_next_page;
  logic [15:0] rd_xfer_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic        err_runaway;
  logic        busy;

  modport master (
    input  req_valid, req_head, req_tail, req_last_batch, out_hold,
           rd_next_page, rd_xfer_data,
    output req_ready, rd_page_down, rd_sram, rd_page,
           out_valid, out_data, out_sop, out_eop, err_runaway, busy
  );

  modport slave (
    output req_valid, req_head, req_tail, req_last_batch, out_hold,
           rd_next_page, rd_xfer_data,
    input  req_ready, rd_page_down, rd_sram, rd_page,
           out_valid, out_data, out_sop, out_eop, err_runaway, busy
  );
endinterface

// File: rtl/pkt_read_sequencer.sv
// Drains one queued packet from the SRAM page store, page by page, following
// the jump-table chain from head to tail, and frames the slice stream.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         pkt_read_sequencer_if.master (descriptor in, SRAM read side,
//               framed output, err_runaway, busy)
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for a descriptor, req_ready high
// S_ISSUE  | page-down for cur pending (first page, or boundary without hold)
// S_STREAM | addressing slices 1..7 of the current page
// S_HOLD   | page boundary reached with out_hold high; address still old page
module pkt_read_sequencer #(
  parameter int MAX_PAGES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pkt_read_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_HOLD} state_t;

  localparam logic [5:0] MAX_CNT = 6'(MAX_PAGES);

  state_t      state, state_nxt;
  logic [11:0] cur, nxt, tail;
  logic [2:0]  last_batch, batch;
  logic [5:0]  page_cnt;
  logic        first, last_pg, abort_pg;

  logic        v1, sop1, eop1, err1;

  logic [11:0] pd_addr;
  logic [5:0]  cnt_inc;
  logic        page_down, pd_last, pd_abort, pd_done, strm_done;
  logic        addr_fire, sop_a, eop_a, err_a;
  logic [2:0]  end_idx;

  // Leaving HOLD jumps straight to the next page; until then the old page
  // stays on the address lines.
  always_comb begin
    pd_addr   = ((state == S_HOLD) && !bus.out_hold) ? nxt : cur;
    page_down = ((state == S_ISSUE) || (state == S_HOLD)) && !bus.out_hold;
    cnt_inc   = page_cnt + 6'd1;
    pd_last   = (pd_addr == tail) || (cnt_inc == MAX_CNT);
    pd_abort  = (pd_addr != tail) && (cnt_inc == MAX_CNT);
    end_idx   = abort_pg ? 3'd7 : last_batch;
    strm_done = (state == S_STREAM) && last_pg && (batch == end_idx);
    // slice 0 is addressed in the page-down cycle, so last_batch==0 ends there
    pd_done   = page_down && pd_last && !pd_abort && (last_batch == 3'd0);
    addr_fire = page_down || (state == S_STREAM);
    sop_a     = page_down && first;
    eop_a     = pd_done || strm_done;
    err_a     = strm_done && abort_pg;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.req_valid) state_nxt = S_ISSUE;
      S_ISSUE,
      S_HOLD:   if (page_down) state_nxt = pd_done ? S_IDLE : S_STREAM;
      S_STREAM: begin
        if (strm_done)            state_nxt = S_IDLE;
        else if (batch == 3'd7)   state_nxt = bus.out_hold ? S_HOLD : S_ISSUE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur        <= '0;
      nxt        <= '0;
      tail       <= '0;
      last_batch <= '0;
      batch      <= '0;
      page_cnt   <= '0;
      first      <= 1'b0;
      last_pg    <= 1'b0;
      abort_pg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            cur        <= bus.req_head;
            tail       <= bus.req_tail;
            last_batch <= bus.req_last_batch;
            page_cnt   <= '0;
            first      <= 1'b1;
          end
        end
        S_ISSUE,
        S_HOLD: begin
          if (page_down) begin
            cur      <= pd_addr;
            batch    <= 3'd1;
            page_cnt <= cnt_inc;
            first    <= 1'b0;
            last_pg  <= pd_last;
            abort_pg <= pd_abort;
          end
        end
        S_STREAM: begin
          if (batch != 3'd7) batch <= batch + 3'd1;
          // jump-table output is valid from the cycle after page-down
          if (batch == 3'd1) nxt <= bus.rd_next_page;
          if (!strm_done && (batch == 3'd7) && !bus.out_hold) cur <= nxt;
        end
        default: ;
      endcase
    end
  end

  // Slice k is addressed at P+k, arrives at P+1+k, and is presented at P+2+k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1              <= 1'b0;
      sop1            <= 1'b0;
      eop1            <= 1'b0;
      err1            <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.out_sop     <= 1'b0;
      bus.out_eop     <= 1'b0;
      bus.err_runaway <= 1'b0;
    end else begin
      v1              <= addr_fire;
      sop1            <= sop_a;
      eop1            <= eop_a;
      err1            <= err_a;
      bus.out_valid   <= v1;
      bus.out_sop     <= sop1;
      bus.out_eop     <= eop1;
      bus.err_runaway <= err1;
      if (v1) bus.out_data <= bus.rd_xfer_data;
    end
  end

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.rd_page_down = page_down;
  assign bus.rd_sram      = pd_addr[11:8];
  assign bus.rd_page      = pd_addr[7:0];

endmodule

// File: tb/tb_pkt_read_sequencer.sv
module tb_pkt_read_sequencer;
  localparam int MAXP = 4;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  f;   // {sop, eop, err}
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pkt_read_sequencer_if bus ();

  pkt_read_sequencer #(.MAX_PAGES(MAXP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] tbl [4096];
  exp_t        exp_q [$];
  logic [11:0] pd_q [$];
  int pd_log [$], ov_log [$], sop_log [$], eop_log [$], err_log [$], rdy_log [$];
  logic rdy_prev = 1'b1;
  exp_t e;
  int   kk = 7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] slice_val(input logic [11:0] a, input int k);
    logic [2:0] k3;
    k3 = 3'(k);
    return {1'b0, a, k3};
  endfunction

  // SRAM read side: jump table one cycle after page-down, slice k at P+1+k.
  always @(posedge clk) begin
    if (bus.rd_page_down) kk = 0;
    else if (kk != 7) kk = kk + 1;
    bus.rd_xfer_data <= slice_val({bus.rd_sram, bus.rd_page}, kk);
    if (bus.rd_page_down) bus.rd_next_page <= tbl[{bus.rd_sram, bus.rd_page}];
  end

  always @(negedge clk) begin
    if (bus.out_valid) begin
      ov_log.push_back(cyc);
      if (bus.out_sop) sop_log.push_back(cyc);
      if (bus.out_eop) eop_log.push_back(cyc);
      if (bus.err_runaway) err_log.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_extra", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", {16'd0, bus.out_data}, {16'd0, e.d});
        chk("sb_flags", {29'd0, bus.out_sop, bus.out_eop, bus.err_runaway}, {29'd0, e.f});
      end
    end else if (bus.err_runaway) chk("err_no_valid", 1, 0);
    if (bus.rd_page_down) begin
      pd_log.push_back(cyc);
      if (pd_q.size() == 0) chk("pd_extra", 1, 0);
      else chk("pd_addr", {20'd0, bus.rd_sram, bus.rd_page}, {20'd0, pd_q.pop_front()});
    end
    if (bus.req_ready && !rdy_prev) rdy_log.push_back(cyc);
    rdy_prev = bus.req_ready;
  end

  task automatic clear_logs();
    pd_log.delete(); ov_log.delete(); sop_log.delete();
    eop_log.delete(); err_log.delete(); rdy_log.delete();
  endtask

  // Reference walk of the chain: page addresses and framed slices.
  task automatic push_expect(input logic [11:0] head, input logic [11:0] tl, input logic [2:0] lb);
    logic [11:0] c;
    int cnt, n;
    logic last, abrt;
    exp_t x;
    c = head;
    cnt = 0;
    forever begin
      cnt++;
      last = (c == tl) || (cnt == MAXP);
      abrt = (c != tl) && (cnt == MAXP);
      n = last ? (abrt ? 7 : int'(lb)) : 7;
      pd_q.push_back(c);
      for (int k = 0; k <= n; k++) begin
        x.d = slice_val(c, k);
        x.f = {(cnt == 1) && (k == 0), last && (k == n), abrt && (k == n)};
        exp_q.push_back(x);
      end
      if (last) break;
      c = tbl[c];
    end
  endtask

  task automatic send(input logic [11:0] head, input logic [11:0] tl, input logic [2:0] lb,
                      input bit keep, output int t);
    bit got;
    got = 0;
    t = 0;
    bus.req_head = head;
    bus.req_tail = tl;
    bus.req_last_batch = lb;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        got = 1;
        t = cyc;
        push_expect(head, tl, lb);
        break;
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int t, t2, p;

  initial begin
    for (int i = 0; i < 4096; i++) tbl[i] = 12'h000;
    tbl[12'h010] = 12'h011;
    tbl[12'h011] = 12'h2A0;
    tbl[12'h020] = 12'h021;
    for (int i = 0; i < 8; i++) tbl[12'h300 + i] = 12'(12'h301 + i);

    bus.req_valid = 1'b0;
    bus.req_head = '0;
    bus.req_tail = '0;
    bus.req_last_batch = '0;
    bus.out_hold = 1'b0;
    bus.rd_next_page = '0;
    bus.rd_xfer_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.req_ready}, 1);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_addr", {20'd0, bus.rd_sram, bus.rd_page}, 0);
    chk("rst_err", {31'd0, bus.err_runaway}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single page, last_batch 3
    clear_logs();
    send(12'h105, 12'h105, 3'd3, 0, t);
    wait_idle();
    chk("sp_pd_cnt", pd_log.size(), 1);
    chk("sp_pd_cyc", pd_log[0], t + 1);
    chk("sp_ov_cnt", ov_log.size(), 4);
    chk("sp_ov_first", ov_log[0], t + 3);
    chk("sp_sop_cyc", sop_log[0], t + 3);
    chk("sp_eop_cyc", eop_log[0], t + 6);
    chk("sp_ready_cyc", rdy_log[0], t + 5);

    // three-page chain, back-to-back pages
    clear_logs();
    send(12'h010, 12'h2A0, 3'd7, 0, t);
    wait_idle();
    p = t + 1;
    chk("tp_pd_cnt", pd_log.size(), 3);
    chk("tp_pd1", pd_log[1], p + 8);
    chk("tp_pd2", pd_log[2], p + 16);
    chk("tp_ov_cnt", ov_log.size(), 24);
    chk("tp_ov_first", ov_log[0], p + 2);
    chk("tp_ov_last", ov_log[23], p + 25);
    chk("tp_eop_cnt", eop_log.size(), 1);
    chk("tp_eop_cyc", eop_log[0], p + 25);

    // out_hold over the page boundary
    clear_logs();
    send(12'h010, 12'h011, 3'd7, 0, t);
    p = t + 1;
    repeat (3) @(posedge clk);
    #1;
    bus.out_hold = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("hold_page_p12", {24'd0, bus.rd_page}, 32'h10);
    chk("hold_pd_p12", {31'd0, bus.rd_page_down}, 0);
    @(posedge clk);
    #1;
    bus.out_hold = 1'b0;
    #1;
    chk("hold_page_p13", {24'd0, bus.rd_page}, 32'h11);
    wait_idle();
    chk("hold_pd_cnt", pd_log.size(), 2);
    chk("hold_pd1", pd_log[1], p + 13);
    chk("hold_gap", ov_log[8] - ov_log[7] - 1, 5);

    // runaway chain never reaching tail
    clear_logs();
    send(12'h300, 12'h3FF, 3'd2, 0, t);
    wait_idle();
    chk("ra_pd_cnt", pd_log.size(), MAXP);
    chk("ra_err_cnt", err_log.size(), 1);
    chk("ra_err_eop", err_log[0], eop_log[0]);
    chk("ra_ov_cnt", ov_log.size(), 8 * MAXP);
    chk("ra_busy", {31'd0, bus.busy}, 0);

    // back-to-back descriptors with req_valid held; second is last_batch 0
    clear_logs();
    send(12'h020, 12'h021, 3'd5, 1, t);
    send(12'h0FF, 12'h0FF, 3'd0, 0, t2);
    wait_idle();
    chk("bb_ov_cnt", ov_log.size(), 15);
    chk("bb_sop_cnt", sop_log.size(), 2);
    chk("bb_sop_after", {31'd0, sop_log[1] > eop_log[0]}, 1);
    chk("bb_single_slice", eop_log[1], sop_log[1]);

    // reset in the middle of a packet
    clear_logs();
    send(12'h010, 12'h2A0, 3'd7, 0, t);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'd0, bus.out_valid}, 0);
    chk("mr_pd", {31'd0, bus.rd_page_down}, 0);
    exp_q.delete();
    pd_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_ready", {31'd0, bus.req_ready}, 1);
    chk("mr_busy", {31'd0, bus.busy}, 0);
    clear_logs();
    send(12'h105, 12'h105, 3'd3, 0, t);
    wait_idle();
    chk("mr_after_ov", ov_log.size(), 4);
    chk("mr_after_eop", eop_log.size(), 1);

    chk("sb_left", exp_q.size(), 0);
    chk("pd_left", pd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
